flag_register_unit: RTL
=======================

Name: flag_register_unit

Overview:
- Writer side of the processor's condition flags: computes NZVC from the current ALU operation and holds them in a 4-bit status register.
- The conditional logic reads this register each cycle via `Flags` and returns `CondEx`.
- Also handles explicit flag writes (MSR-style) and a one-deep save/restore of the flags across exception entry and return.
- Sits between the ALU and the conditional logic.

Parameters:
- WIDTH, 32, datapath width of SrcA/SrcB/ALUResult.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- SrcA  input  WIDTH  ALU operand A.
- SrcB  input  WIDTH  ALU operand B.
- ALUResult  input  WIDTH  ALU result for the current instruction.
- ALUControl  input  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- FlagW  input  2  [1] write N,Z; [0] write V,C.
- CondEx  input  1  current instruction passes its condition.
- MsrWrite  input  1  explicit flag write request.
- MsrData  input  4  flag value for an explicit write, in the Flags bit order.
- ExcEntry  input  1  exception entry pulse.
- ExcReturn  input  1  exception return pulse.
- ALUFlags  output  4  combinational flags of the current op: [3]N [2]Z [1]V [0]C.
- Flags  output  4  registered status flags, same bit order; feeds the conditional logic.
- SavedFlags  output  4  saved-flags register.
- SaveValid  output  1  SavedFlags holds a live save.
- ProtErr  output  1  one-cycle pulse on an illegal exception sequence.

Behaviour:
- Reset: Flags=0000, SavedFlags=0000, SaveValid=0, ProtErr=0. Reset overrides every other input in the same cycle.
- Flag computation (combinational):
  - N = ALUResult[WIDTH-1]; Z = (ALUResult == 0).
  - ADD: {C,sum} = SrcA + SrcB with a WIDTH+1-bit add; V = (A[msb]==B[msb]) & (sum[msb]!=A[msb]).
  - SUB: {C,diff} = SrcA + ~SrcB + 1, so C=1 means no borrow; V = (A[msb]!=B[msb]) & (diff[msb]!=A[msb]).
  - AND/ORR: C=0, V=0.
  - N and Z come from ALUResult, not from the internal sum.
- Update priority per cycle, highest first: Reset > ExcEntry > ExcReturn > MsrWrite > ALU update. Only the winning source modifies Flags in that cycle.
- ExcEntry:
  - If SaveValid=0: SavedFlags<=Flags (the pre-edge value) and SaveValid<=1; Flags unchanged.
  - If SaveValid=1 (nested entry): no overwrite and ProtErr<=1.
- ExcReturn (without ExcEntry):
  - If SaveValid=1: Flags<=SavedFlags and SaveValid<=0.
  - If SaveValid=0: ignored and ProtErr<=1.
- ExcEntry and ExcReturn in the same cycle: entry is processed per the rules above, return is dropped, and ProtErr<=1.
- MsrWrite: Flags<=MsrData, all 4 bits, regardless of CondEx and FlagW.
- ALU update:
  - Flags[3:2]<=ALUFlags[3:2] iff FlagW[1]&CondEx.
  - Flags[1:0]<=ALUFlags[1:0] iff FlagW[0]&CondEx.
  - The two halves are independent.
- CondEx=0 blocks all ALU flag writes.
- ProtErr is a registered pulse: high for exactly one cycle after an offending edge, otherwise 0.
- Latency: a flag write becomes visible on Flags one cycle after the edge. There is no bypass; the conditional logic always sees the registered value.
- Wrap-around: 0xFFFFFFFF+1 gives Z=1, C=1, V=0; 0x7FFFFFFF+1 gives N=1, V=1, C=0.

Test Plan:
- ADD: SrcA=0x7FFFFFFF, SrcB=1, ALUResult=0x80000000, FlagW=11, CondEx=1 -> next cycle Flags=1010 (N=1, Z=0, V=1, C=0).
- SUB: SrcA=5, SrcB=5, ALUResult=0, FlagW=11, CondEx=1 -> Flags=0101 (Z=1, C=1). Then the same op with CondEx=0 and ALUResult=1 -> Flags unchanged at 0101.
- Partial write: Flags=0101, AND with ALUResult=0x80000000, FlagW=10, CondEx=1 -> Flags=1001 (N,Z updated; V,C held).
- Save/restore: Flags=1001, pulse ExcEntry -> SavedFlags=1001, SaveValid=1. Then MsrWrite with MsrData=0110 -> Flags=0110. Then pulse ExcReturn -> Flags=1001, SaveValid=0, ProtErr stays 0.
- Errors:
  - ExcReturn with SaveValid=0 -> Flags unchanged, ProtErr=1 for one cycle.
  - ExcEntry twice -> SavedFlags keeps the first value, ProtErr pulses on the second.
  - ExcEntry and ExcReturn together -> save occurs, ProtErr=1.
- Reset mid-operation: SaveValid=1, Flags=1111, assert Reset together with MsrWrite and ExcReturn -> next cycle all outputs 0.

Source files
------------

// File: rtl/flag_register_unit.sv
// NZVC flag writer: derives ALU flags, holds the status register, and keeps a
// one-deep save slot for exception entry/return with protocol-error reporting.
module flag_register_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [1:0]       ALUControl,
  input  logic [1:0]       FlagW,
  input  logic             CondEx,
  input  logic             MsrWrite,
  input  logic [3:0]       MsrData,
  input  logic             ExcEntry,
  input  logic             ExcReturn,
  output logic [3:0]       ALUFlags,
  output logic [3:0]       Flags,
  output logic [3:0]       SavedFlags,
  output logic             SaveValid,
  output logic             ProtErr
);

  logic             is_sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum_w;
  logic             n_flag;
  logic             z_flag;
  logic             v_flag;
  logic             c_flag;

  logic [3:0] flags_q, flags_d;
  logic [3:0] saved_flags_q, saved_flags_d;
  logic       save_valid_q, save_valid_d;
  logic       prot_err_q, prot_err_d;

  // SUB is A + ~B + 1; with b_op already inverted, the ADD overflow rule
  // (operands agree in sign, result differs) covers both cases.
  always_comb begin
    is_sub = (ALUControl == 2'b01);
    b_op   = is_sub ? ~SrcB : SrcB;
    sum_w  = {1'b0, SrcA} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
    n_flag = ALUResult[WIDTH-1];
    z_flag = (ALUResult == '0);
    v_flag = 1'b0;
    c_flag = 1'b0;
    if (!ALUControl[1]) begin
      c_flag = sum_w[WIDTH];
      v_flag = (SrcA[WIDTH-1] == b_op[WIDTH-1]) &&
               (sum_w[WIDTH-1] != SrcA[WIDTH-1]);
    end
    ALUFlags = {n_flag, z_flag, v_flag, c_flag};
  end

  always_comb begin
    flags_d       = flags_q;
    saved_flags_d = saved_flags_q;
    save_valid_d  = save_valid_q;
    prot_err_d    = 1'b0;
    if (ExcEntry) begin
      if (!save_valid_q) begin
        saved_flags_d = flags_q;
        save_valid_d  = 1'b1;
      end else begin
        prot_err_d = 1'b1;
      end
      // A simultaneous return is dropped and reported.
      if (ExcReturn) prot_err_d = 1'b1;
    end else if (ExcReturn) begin
      if (save_valid_q) begin
        flags_d      = saved_flags_q;
        save_valid_d = 1'b0;
      end else begin
        prot_err_d = 1'b1;
      end
    end else if (MsrWrite) begin
      flags_d = MsrData;
    end else begin
      if (FlagW[1] && CondEx) flags_d[3:2] = ALUFlags[3:2];
      if (FlagW[0] && CondEx) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      flags_q       <= 4'b0000;
      saved_flags_q <= 4'b0000;
      save_valid_q  <= 1'b0;
      prot_err_q    <= 1'b0;
    end else begin
      flags_q       <= flags_d;
      saved_flags_q <= saved_flags_d;
      save_valid_q  <= save_valid_d;
      prot_err_q    <= prot_err_d;
    end
  end

  assign Flags      = flags_q;
  assign SavedFlags = saved_flags_q;
  assign SaveValid  = save_valid_q;
  assign ProtErr    = prot_err_q;

endmodule
